butterfly_weight_streamer: RTL

// - Buffers all per-stage butterfly weights for one transform and replays them to butterfly_processor.up_weight_dat/vld.
// - Weights are loaded once, then replayed stage by stage, optionally for several passes (e.g. one pass per BE batch).
// - Runtime length up to MAX_LENGTH; stage count and per-stage depth derive from length.
// - Sits between the host/DMA weight port and the butterfly processor, replacing host-driven per-cycle weight feeding.

---
 rtl/butterfly_weight_streamer.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/butterfly_weight_streamer.sv
// Butterfly weight streamer: buffers one transform's per-stage weights and
// replays them, stage by stage, to the butterfly processor for N passes.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   length           transform length, sampled on an accepted load_start
//   num_passes       replay count, sampled on stream_start (0 behaves as 1)
//   load_start       pulse: begin loading a weight set
//   stream_start     pulse: begin replaying the loaded set
//   wr_vld/dat/rdy   weight write port (accepted in LOAD only)
//   dn_vld/dat/rdy   replayed weight stream
//   busy             high in LOAD or STREAM
//   loaded           buffer holds a complete weight set
//   done             high on the final dn handshake of the final pass
//   err_len          sticky length error, cleared by the next valid load
//   stall_cnt        (BFLY_WSTREAM_STALL_CNT_EN only) dn stall cycles
//
// Optional feature macro: BFLY_WSTREAM_STALL_CNT_EN.
module butterfly_weight_streamer #(
  parameter  int DATA_WIDTH     = 16,
  parameter  int BU_PARALLELISM = 4,
  parameter  int MAX_LENGTH     = 1024,
  localparam int WORD_W = DATA_WIDTH * 4 * BU_PARALLELISM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       length,
  input  logic [7:0]        num_passes,
  input  logic              load_start,
  input  logic              stream_start,
  input  logic              wr_vld,
  input  logic [WORD_W-1:0] wr_dat,
  output logic              wr_rdy,
  output logic              dn_vld,
  output logic [WORD_W-1:0] dn_dat,
  input  logic              dn_rdy,
  output logic              busy,
  output logic              loaded,
  output logic              done,
  output logic              err_len
`ifdef BFLY_WSTREAM_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int MAX_DEPTH  = MAX_LENGTH / (2 * BU_PARALLELISM);
  localparam int MAX_STAGES = $clog2(MAX_LENGTH);
  localparam int MAX_TOTAL  = MAX_STAGES * MAX_DEPTH;
  localparam int AW         = $clog2(MAX_TOTAL + 1);
  localparam int DSH        = $clog2(2 * BU_PARALLELISM);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_LOADED,
    S_STREAM
  } state_t;

  state_t state_q, state_d;

  logic          err_q, err_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] total_q, total_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]    pass_q, pass_d;
  logic [7:0]    passes_q, passes_d;
  logic          rd_fin_q, rd_fin_d;
  logic          rd_vld_q;
  logic [1:0]    cnt_q, cnt_d;
  logic [WORD_W-1:0] rd_dat_q;
  logic [WORD_W-1:0] s0_q, s0_d;
  logic [WORD_W-1:0] s1_q, s1_d;

  logic [WORD_W-1:0] mem [MAX_TOTAL];

  // Length decode
  logic          len_ok_c;
  logic [AW-1:0] stages_c;
  logic [AW-1:0] depth_c;
  logic [AW-1:0] total_c;

  always_comb begin
    stages_c = '0;
    for (int i = 0; i < 16; i++) begin
      if (length[i]) stages_c = AW'(i);
    end
  end

  assign len_ok_c = (length != 16'd0)
                 && ((length & (length - 16'd1)) == 16'd0)
                 && (length >= 16'(2 * BU_PARALLELISM))
                 && (length <= 16'(MAX_LENGTH));
  assign depth_c  = AW'(length >> DSH);
  assign total_c  = stages_c * depth_c;

  // Handshakes
  logic wr_hs_c;
  logic start_c;
  logic pop_c;
  logic done_c;

  assign wr_hs_c = wr_vld && (state_q == S_LOAD);
  // load_start has priority over stream_start in LOADED
  assign start_c = (state_q == S_LOADED) && stream_start && !load_start;
  assign pop_c   = (cnt_q != 2'd0) && dn_rdy;
  // Last word leaves when every read is issued and nothing is in flight
  assign done_c  = (state_q == S_STREAM) && pop_c && rd_fin_q
                && !rd_vld_q && (cnt_q == 2'd1);

  // Read issue: keep (skid occupancy + in-flight read) within 2 entries
  logic [2:0]    occ_c;
  logic          space_c;
  logic          rd_en_c;
  logic [AW-1:0] cur_addr_c;
  logic [7:0]    cur_pass_c;
  logic [7:0]    cur_passes_c;
  logic [7:0]    np_c;

  assign occ_c   = 3'(cnt_q) + 3'(rd_vld_q) - 3'(pop_c);
  assign space_c = occ_c < 3'd2;
  assign np_c    = (num_passes == 8'd0) ? 8'd1 : num_passes;

  // The first read is issued in the stream_start cycle itself
  assign cur_addr_c   = start_c ? '0 : rd_addr_q;
  assign cur_pass_c   = start_c ? 8'd0 : pass_q;
  assign cur_passes_c = start_c ? np_c : passes_q;
  assign rd_en_c      = space_c
                     && (start_c || ((state_q == S_STREAM) && !rd_fin_q));

  always_comb begin
    rd_addr_d = rd_addr_q;
    pass_d    = pass_q;
    passes_d  = passes_q;
    rd_fin_d  = rd_fin_q;
    if (start_c) begin
      rd_addr_d = '0;
      pass_d    = 8'd0;
      passes_d  = np_c;
      rd_fin_d  = 1'b0;
    end
    if (rd_en_c) begin
      if (cur_addr_c == total_q - AW'(1)) begin
        rd_addr_d = '0;
        if (cur_pass_c == cur_passes_c - 8'd1) begin
          rd_fin_d = 1'b1;
        end else begin
          pass_d = cur_pass_c + 8'd1;
        end
      end else begin
        rd_addr_d = cur_addr_c + AW'(1);
      end
    end
  end

  // Two-entry skid: s0 is the head, shown on dn_dat
  logic [1:0] pos_c;

  always_comb begin
    pos_c = cnt_q - {1'b0, pop_c};
    s0_d  = s0_q;
    s1_d  = s1_q;
    if (pop_c) s0_d = s1_q;
    if (rd_vld_q) begin
      if (pos_c == 2'd0) s0_d = rd_dat_q;
      else               s1_d = rd_dat_q;
    end
    cnt_d = pos_c + {1'b0, rd_vld_q};
  end

  // FSM next state
  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    wr_addr_d = wr_addr_q;
    total_d   = total_q;
    unique case (state_q)
      S_IDLE, S_LOADED: begin
        if (load_start) begin
          if (len_ok_c) begin
            state_d   = S_LOAD;
            err_d     = 1'b0;
            wr_addr_d = '0;
            total_d   = total_c;
          end else begin
            err_d = 1'b1;
          end
        end else if (start_c) begin
          state_d = S_STREAM;
        end
      end
      S_LOAD: begin
        if (wr_hs_c) begin
          wr_addr_d = wr_addr_q + AW'(1);
          if (wr_addr_q == total_q - AW'(1)) state_d = S_LOADED;
        end
      end
      S_STREAM: begin
        if (done_c) state_d = S_LOADED;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      err_q     <= 1'b0;
      wr_addr_q <= '0;
      total_q   <= '0;
      rd_addr_q <= '0;
      pass_q    <= '0;
      passes_q  <= '0;
      rd_fin_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
      cnt_q     <= '0;
      s0_q      <= '0;
      s1_q      <= '0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      wr_addr_q <= wr_addr_d;
      total_q   <= total_d;
      rd_addr_q <= rd_addr_d;
      pass_q    <= pass_d;
      passes_q  <= passes_d;
      rd_fin_q  <= rd_fin_d;
      rd_vld_q  <= rd_en_c;
      cnt_q     <= cnt_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
    end
  end

  // Weight buffer, synchronous read
  always_ff @(posedge clk) begin
    if (wr_hs_c) mem[wr_addr_q] <= wr_dat;
    if (rd_en_c) rd_dat_q <= mem[cur_addr_c];
  end

`ifdef BFLY_WSTREAM_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (start_c) begin
      stall_q <= '0;
    end else if ((state_q == S_STREAM) && dn_vld && !dn_rdy
                 && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

  assign wr_rdy  = (state_q == S_LOAD);
  assign dn_vld  = (cnt_q != 2'd0);
  assign dn_dat  = s0_q;
  assign busy    = (state_q == S_LOAD) || (state_q == S_STREAM);
  assign loaded  = (state_q == S_LOADED) || (state_q == S_STREAM);
  assign done    = done_c;
  assign err_len = err_q;

endmodule
